// File: rtl/adder_pkg.sv
// Shared constants and elaboration helpers for the carry-pipelined adder.
package adder_pkg;

  localparam int unsigned ADDER_WIDTH_DEFAULT  = 8;
  localparam int unsigned ADDER_STAGES_DEFAULT = 2;

  // Bits handled by each pipeline stage; guarded so an illegal STAGES=0 still elaborates to the check.
  function automatic int unsigned chunk_width(input int unsigned width, input int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

  // Legal when the operand splits into STAGES equal, non-empty chunks.
  function automatic bit params_legal(input int unsigned width, input int unsigned stages);
    return (width >= 1) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CW-bit ripple adder built from full-adder cells.
module adder_chunk #(
  parameter int unsigned CW = 4
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          c_in,
  output logic [CW-1:0] s,
  output logic          c_out,
  output logic          c_msb_in
);

  // Ripple the carry upward, tapping the carry that enters the top cell for signed overflow.
  always_comb begin
    logic carry;
    carry    = c_in;
    s        = '0;
    c_msb_in = c_in;
    for (int unsigned i = 0; i < CW; i++) begin
      if (i == CW - 1) c_msb_in = carry;
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    c_out = carry;
  end

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder split into STAGES carry-pipelined chunks behind valid/ready handshakes.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = ADDER_WIDTH_DEFAULT,
  parameter int unsigned STAGES = ADDER_STAGES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int unsigned CW   = chunk_width(WIDTH, STAGES);
  localparam int unsigned LAST = STAGES - 1;

  if (!params_legal(WIDTH, STAGES)) begin : g_param_check
    $error("pipelined_adder: need 1 <= STAGES <= WIDTH with WIDTH divisible by STAGES");
  end

  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;

  // Walk from the output back: a stage advances when its successor is free or itself advancing.
  always_comb begin
    logic free_next;
    adv       = '0;
    free_next = out_ready;
    for (int unsigned i = 0; i < STAGES; i++) begin
      adv[LAST-i] = v_q[LAST-i] & free_next;
      free_next   = ~v_q[LAST-i] | adv[LAST-i];
    end
    in_ready = free_next;
  end

  // Stage k fills when its upstream hands over and empties when it advances without a refill.
  always_comb begin
    load    = '0;
    load[0] = in_valid & in_ready;
    for (int unsigned k = 1; k < STAGES; k++) begin
      load[k] = adv[k-1];
    end
    v_d = load | (v_q & ~adv);
  end

  // Stage valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v_q <= '0;
    else        v_q <= v_d;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned IW = WIDTH - k * CW;   // operand bits not yet summed on entry
    localparam int unsigned SW = (k + 1) * CW;     // sum bits held after this stage

    logic [IW-1:0] src_a, src_b;
    logic          src_c;
    logic [CW-1:0] ch_s;
    logic          ch_co, ch_cm;
    logic [SW-1:0] s_q, s_d;
    logic          c_q, c_d;

    adder_chunk #(.CW(CW)) u_chunk (
      .a        (src_a[CW-1:0]),
      .b        (src_b[CW-1:0]),
      .c_in     (src_c),
      .s        (ch_s),
      .c_out    (ch_co),
      .c_msb_in (ch_cm)
    );

    if (k == 0) begin : g_src
      assign src_a = a;
      assign src_b = b;
      assign src_c = c_in;

      // First chunk straight from the operand ports.
      always_comb begin
        s_d = s_q;
        c_d = c_q;
        if (load[k]) begin
          s_d = ch_s;
          c_d = ch_co;
        end
      end
    end else begin : g_src
      assign src_a = g_stage[k-1].g_ops.ra_q;
      assign src_b = g_stage[k-1].g_ops.rb_q;
      assign src_c = g_stage[k-1].c_q;

      // Append this chunk above the sum bits produced upstream.
      always_comb begin
        s_d = s_q;
        c_d = c_q;
        if (load[k]) begin
          s_d = {ch_s, g_stage[k-1].s_q};
          c_d = ch_co;
        end
      end
    end

    // Partial sum and chunk carry registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q <= '0;
        c_q <= 1'b0;
      end else begin
        s_q <= s_d;
        c_q <= c_d;
      end
    end

    if (k < STAGES - 1) begin : g_ops
      logic [IW-CW-1:0] ra_q, ra_d, rb_q, rb_d;

      // Forward the untouched upper operand bits, shifted so the next chunk sits at bit 0.
      always_comb begin
        ra_d = ra_q;
        rb_d = rb_q;
        if (load[k]) begin
          ra_d = src_a[IW-1:CW];
          rb_d = src_b[IW-1:CW];
        end
      end

      // Upper operand registers.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ra_q <= '0;
          rb_q <= '0;
        end else begin
          ra_q <= ra_d;
          rb_q <= rb_d;
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic ovf_q, ovf_d;

      // Signed overflow: carry into the MSB differs from carry out of it.
      always_comb begin
        ovf_d = ovf_q;
        if (load[k]) ovf_d = ch_cm ^ ch_co;
      end

      // Overflow register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = v_q[LAST];
  assign sum       = g_stage[LAST].s_q;
  assign c_out     = g_stage[LAST].c_q;
  assign overflow  = g_stage[LAST].g_last.ovf_q;

endmodule
